// File: rtl/mc_mips_pkg.sv
// rtl/mc_mips_pkg.sv - shared types and constants for the multi-cycle MIPS memory
package mc_mips_pkg;

  localparam int WORD_W      = 32;
  localparam int LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mc_mips_mem_array.sv
// rtl/mc_mips_mem_array.sv - word array, synchronous write and combinational read
module mc_mips_mem_array
  import mc_mips_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  // No reset on purpose: preloaded images must survive a core reset.
  logic [WORD_W-1:0] mem_data [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[waddr] <= wdata;
    end
  end

  assign rdata = mem_data[raddr];

endmodule

// File: rtl/mc_mips_wait_mem.sv
// rtl/mc_mips_wait_mem.sv - unified I/D memory with request/response handshake and wait states
module mc_mips_wait_mem
  import mc_mips_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              addr_err
);

  localparam int                AW         = $clog2(DEPTH);
  localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(DEPTH * 4);
  localparam logic [3:0]        LAT_INIT   = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [WORD_W-1:0] addr_q, wdata_q;
  logic              we_q;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;

  logic              access;
  logic              bad_addr;
  logic              mem_we;
  logic [AW-1:0]     idx;
  logic [WORD_W-1:0] mem_rdata;

  assign idx      = addr_q[2 +: AW];
  assign bad_addr = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIMIT);
  assign access   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  // Gating with reset keeps a write pending at a reset edge from committing.
  assign mem_we   = reset && access && we_q && !bad_addr;

  mc_mips_mem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) mem (
    .clk  (clk),
    .wr_en(mem_we),
    .waddr(idx),
    .wdata(wdata_q),
    .raddr(idx),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = reset;
        if (req_valid) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            cnt_q   <= LAT_INIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            err_q   <= bad_addr;
            rdata_q <= (bad_addr || we_q) ? '0 : mem_rdata;
          end
        end
        ST_RESP: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = rdata_q;
  assign addr_err   = err_q;

endmodule

// File: tb/tb_mc_mips_wait_mem.sv
// tb/tb_mc_mips_wait_mem.sv - directed scoreboard bench for mc_mips_wait_mem
module tb_mc_mips_wait_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        a_valid = 1'b0, a_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic        a_ready, a_resp, a_err;
  logic [31:0] a_rdata;

  logic        b_valid = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        b_ready, b_resp, b_err;
  logic [31:0] b_rdata;

  int total = 0;
  int bad   = 0;
  logic [32:0] sb [$];

  always #5 clk = ~clk;

  mc_mips_wait_mem #(.DEPTH(1024), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
    .req_ready(a_ready), .resp_valid(a_resp), .resp_rdata(a_rdata), .addr_err(a_err)
  );

  mc_mips_wait_mem #(.DEPTH(1024), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
    .req_ready(b_ready), .resp_valid(b_resp), .resp_rdata(b_rdata), .addr_err(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic err, input logic [31:0] rdata);
    logic [32:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_err"}, 32'(err), 32'(e[32]));
      check({tag, "_rdata"}, rdata, e[31:0]);
    end
  endtask

  // Drives one access on dut_a (LATENCY=2); called and returns at a negedge.
  task automatic access_a(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err,
                          input logic [31:0] exp_rdata);
    int n;
    sb.push_back({exp_err, exp_rdata});
    a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    n = 0;
    while (!a_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, "_ready"}, 32'(a_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    n = 1;
    while (!a_resp && n < 20) begin
      check({tag, "_busy"}, 32'(a_ready), 32'd0);
      @(negedge clk); n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd3);
    if (a_resp) pop_check(tag, a_err, a_rdata);
    else        check({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(a_resp), 32'd0);
    check({tag, "_ready_back"}, 32'(a_ready), 32'd1);
    check({tag, "_err_clr"}, 32'(a_err), 32'd0);
    check({tag, "_rdata_clr"}, a_rdata, 32'd0);
  endtask

  initial begin
    logic [7:0] acc_mask, resp_mask;

    // Reset held with a request pending: nothing may be accepted
    a_valid = 1'b1; a_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", 32'(a_ready), 32'd0);
      check("rst_resp", 32'(a_resp), 32'd0);
      check("rst_rdata", a_rdata, 32'd0);
    end
    dut_a.mem.mem_data[32] = 32'hDEADBEEF;
    dut_a.mem.mem_data[34] = 32'h5A5A0000;
    dut_b.mem.mem_data[32] = 32'hCAFEF00D;
    dut_b.mem.mem_data[33] = 32'h0BADC0DE;
    a_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(a_ready), 32'd1);
    check("post_rst_resp", 32'(a_resp), 32'd0);

    access_a("rd80", 1'b0, 32'h80, 32'h0, 1'b0, 32'hDEADBEEF);
    access_a("wr84", 1'b1, 32'h84, 32'h12345678, 1'b0, 32'h0);
    access_a("rd84", 1'b0, 32'h84, 32'h0, 1'b0, 32'h12345678);
    check("mem33", dut_a.mem.mem_data[33], 32'h12345678);
    access_a("wr82_mis", 1'b1, 32'h82, 32'hFFFFFFFF, 1'b1, 32'h0);
    access_a("rd1000_oor", 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0);
    check("mem32_kept", dut_a.mem.mem_data[32], 32'hDEADBEEF);

    // Reset pulled during WAIT discards a pending write
    a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h88; a_wdata = 32'hA5A5A5A5;
    check("mid_ready", 32'(a_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0; a_we = 1'b0;
    check("mid_in_wait", 32'(a_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_no_resp", 32'(a_resp), 32'd0);
      check("mid_idle", 32'(a_ready), 32'd1);
    end
    check("mem34_kept", dut_a.mem.mem_data[34], 32'h5A5A0000);
    access_a("rd88", 1'b0, 32'h88, 32'h0, 1'b0, 32'h5A5A0000);

    // LATENCY=1 back-to-back reads with req_valid held high
    acc_mask = '0; resp_mask = '0;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 32'h80;
    sb.push_back({1'b0, 32'hCAFEF00D});
    sb.push_back({1'b0, 32'h0BADC0DE});
    if (b_ready) acc_mask[0] = 1'b1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) b_addr = 32'h84;
      if (i == 4) b_valid = 1'b0;
      if (b_valid && b_ready) acc_mask[i] = 1'b1;
      if (b_resp) begin
        resp_mask[i] = 1'b1;
        pop_check("b2b", b_err, b_rdata);
      end
    end
    check("b2b_accepts", 32'(acc_mask), 32'h09);
    check("b2b_resps", 32'(resp_mask), 32'h24);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
